// File: rtl/matrix_mem_pkg.sv
// rtl/matrix_mem_pkg.sv - shared types and default sizes for the matrix memory loader
package matrix_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    localparam int DEFAULT_NUM_BANKS  = 2;
    localparam int DEFAULT_BANK_DEPTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/matrix_wr_addr_gen.sv
// rtl/matrix_wr_addr_gen.sv - write address and bank counter with wrap and end flags
module matrix_wr_addr_gen
    import matrix_mem_pkg::*;
#(
    parameter int  NUM_BANKS  = DEFAULT_NUM_BANKS,
    parameter int  BANK_DEPTH = DEFAULT_BANK_DEPTH,
    localparam int ADDR_W     = $clog2(BANK_DEPTH),
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic [BANK_W-1:0] first_bank,
    input  logic              seq_mode,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic [BANK_W-1:0] bank,
    output logic              bank_end,
    output logic              last_bank
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BANK_W-1:0] bank_q, bank_d;

    assign addr      = addr_q;
    assign bank      = bank_q;
    assign bank_end  = (addr_q == ADDR_W'(BANK_DEPTH - 1));
    assign last_bank = (bank_q == BANK_W'(NUM_BANKS - 1));

    always_comb begin
        addr_d = addr_q;
        bank_d = bank_q;
        if (init) begin
            addr_d = '0;
            bank_d = first_bank;
        end else if (advance) begin
            // Explicit wrap keeps non-power-of-two depths correct.
            if (bank_end) begin
                addr_d = '0;
                if (seq_mode && !last_bank) begin
                    bank_d = bank_q + BANK_W'(1);
                end
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            bank_q <= '0;
        end else begin
            addr_q <= addr_d;
            bank_q <= bank_d;
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// rtl/matrix_stream_loader.sv - framed stream loader distributing words into matrix memory banks
module matrix_stream_loader
    import matrix_mem_pkg::*;
#(
    parameter int  NUM_BANKS  = DEFAULT_NUM_BANKS,
    parameter int  BANK_DEPTH = DEFAULT_BANK_DEPTH,
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int ADDR_W     = $clog2(BANK_DEPTH),
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int CNT_W      = $clog2(NUM_BANKS * BANK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  seq_mode,
    input  logic [BANK_W-1:0]     bank_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic [NUM_BANKS-1:0]  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  short_err,
    output logic                  drop_err,
    output logic [CNT_W-1:0]      beat_count
);

    loader_state_t         state_q, state_d;
    logic                  seq_q, seq_d;
    logic                  in_ready_q, in_ready_d;
    logic [NUM_BANKS-1:0]  wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  short_err_q, short_err_d;
    logic                  drop_err_q, drop_err_d;
    logic [CNT_W-1:0]      beat_count_q, beat_count_d;

    logic                  gen_init, gen_advance;
    logic [BANK_W-1:0]     first_bank, cur_bank;
    logic [ADDR_W-1:0]     cur_addr;
    logic                  bank_end, last_bank, beat, final_word;

    matrix_wr_addr_gen #(
        .NUM_BANKS  (NUM_BANKS),
        .BANK_DEPTH (BANK_DEPTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (gen_init),
        .first_bank (first_bank),
        .seq_mode   (seq_q),
        .advance    (gen_advance),
        .addr       (cur_addr),
        .bank       (cur_bank),
        .bank_end   (bank_end),
        .last_bank  (last_bank)
    );

    // Out-of-range selections fold onto the highest bank.
    always_comb begin
        first_bank = '0;
        if (!seq_mode) begin
            if ({1'b0, bank_sel} > (BANK_W + 1)'(NUM_BANKS - 1)) begin
                first_bank = BANK_W'(NUM_BANKS - 1);
            end else begin
                first_bank = bank_sel;
            end
        end
    end

    assign beat       = in_valid && (state_q == LOAD);
    assign final_word = bank_end && (!seq_q || last_bank);

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        wr_en_d      = '0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        short_err_d  = short_err_q;
        drop_err_d   = drop_err_q;
        beat_count_d = beat_count_q;
        gen_init     = 1'b0;
        gen_advance  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    gen_init     = 1'b1;
                    seq_d        = seq_mode;
                    beat_count_d = '0;
                    short_err_d  = 1'b0;
                    drop_err_d   = 1'b0;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    gen_advance  = 1'b1;
                    wr_en_d      = NUM_BANKS'(1) << cur_bank;
                    wr_addr_d    = cur_addr;
                    wr_data_d    = in_data;
                    beat_count_d = beat_count_q + CNT_W'(1);
                    if (final_word) begin
                        state_d = DONE;
                    end else if (in_last) begin
                        short_err_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Data offered while not loading is lost; a drop wins over a same-cycle start clear.
        if (in_valid && (state_q != LOAD)) begin
            drop_err_d = 1'b1;
        end

        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d == LOAD);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            seq_q        <= 1'b0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            short_err_q  <= 1'b0;
            drop_err_q   <= 1'b0;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            short_err_q  <= short_err_d;
            drop_err_q   <= drop_err_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign short_err  = short_err_q;
    assign drop_err   = drop_err_q;
    assign beat_count = beat_count_q;

endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Parametrised successor to the matrix memory write controller. Accepts a single 32-bit-class input word stream with a valid/ready handshake and distributes it into NUM_BANKS matrix memories of BANK_DEPTH words each, either sequentially across all banks or into one selected bank. Adds explicit start/done framing, backpressure, early-termination detection and dropped-data flagging. Sits between the host/stream interface and the matrix A/B/... write ports feeding the multiplier core.

## Interface
- NUM_BANKS, 2, number of target matrix memories (≥1)
- BANK_DEPTH, 8, words per bank (≥2)
- DATA_WIDTH, 32, word width
- ADDR_W, $clog2(BANK_DEPTH), derived localparam; not overridable
- clk  in  1  single clock for stream and all write ports, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- seq_mode  in  1  sampled with start: 1 = fill banks 0..NUM_BANKS-1 in order, 0 = fill bank_sel only
- bank_sel  in  $clog2(NUM_BANKS) (min 1)  target bank in single mode
- in_valid  in  1  input word valid
- in_ready  out  1  loader can accept a word
- in_data  in  DATA_WIDTH  input word
- in_last  in  1  marks final word of the frame, qualified by in_valid
- wr_en  out  NUM_BANKS  one-hot write enable, one bit per bank
- wr_addr  out  ADDR_W  shared write address
- wr_data  out  DATA_WIDTH  shared write data
- busy  out  1  high in LOAD
- done  out  1  one-cycle pulse at frame end
- short_err  out  1  sticky: in_last arrived before the expected final word
- drop_err  out  1  sticky: in_valid seen while not in LOAD
- beat_count  out  $clog2(NUM_BANKS*BANK_DEPTH+1)  words accepted in current/last frame

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: in_ready=0. On start: latch mode and first bank (0 if seq_mode, else bank_sel); addr=0, beat_count=0, clear short_err and drop_err; go to LOAD.
- LOAD: in_ready=1. Beat = in_valid & in_ready. Each beat registers a write of in_data to the current bank at addr; addr increments and beat_count increments.
- Bank end (addr==BANK_DEPTH-1 on a beat): addr wraps to 0. In seq mode, if bank<NUM_BANKS-1, bank increments and the state stays LOAD. Otherwise go to DONE.
- in_last on a beat that is not the expected final word: write that word, set short_err, go to DONE. in_last on the expected final word is legal.
- DONE: done=1 and in_ready=0 for one cycle, then go to IDLE.
- start outside IDLE is ignored.
- in_valid outside LOAD sets drop_err; no write occurs.
- bank_sel ≥ NUM_BANKS in single mode: target bank NUM_BANKS-1.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, short_err=0, drop_err=0, beat_count=0, state=IDLE.
- Write latency: a beat accepted at edge k drives wr_en/wr_addr/wr_data during cycle k..k+1 for exactly one cycle.
- LOAD entered at the edge after start is sampled; in_ready rises in that same cycle.
- Final beat at edge k: done is high during the same cycle as the final write, and busy falls in that cycle. IDLE is entered at edge k+1.
- Gaps (in_valid=0) stall addr and bank with no write; there is no timeout.
- Reset asserted mid-load returns the block to IDLE immediately. Partial writes already issued stand; nothing further is written.

## Structure
- Package matrix_mem_pkg: typedef enum for loader_state_t {IDLE, LOAD, DONE}; shared default constants for DATA_WIDTH and BANK_DEPTH.
- Sub-module matrix_wr_addr_gen: address counter plus bank counter with wrap, bank-end and last-bank flags.
- The top level holds the FSM, the output registers and the error flags.

## Test plan
All scenarios use NUM_BANKS=2, BANK_DEPTH=8.
- Reset: hold rst_n=0 with random inputs -> all outputs 0, in_ready=0.
- Sequential load: start with seq_mode=1, send 16 words 32'hA001_100F..32'hB008_800E with in_valid low for 2 cycles after the 4th -> wr_en=01 at addr 0..7, then wr_en=10 at addr 0..7, data in order; done pulses once, coincident with bank1 addr7; beat_count=16; no errors.
- Single mode: seq_mode=0, bank_sel=1, 8 words -> only wr_en[1] fires, addr 0..7; done after the 8th write; bank 0 untouched.
- Early in_last: seq_mode=1, in_last on the 5th word -> bank0 addr 0..4 written, short_err=1, done pulse, beat_count=5, in_ready=0 afterwards.
- Dropped data: in_valid=1 with 32'hDEAD_BEEF while in IDLE -> drop_err=1, no wr_en. Next start clears drop_err.
- Reset mid-load: assert rst_n=0 after 3 words, release, then start again -> writes restart at bank0 addr0, beat_count restarts from 0.
